bus_arbiter: RTL and testbench

Two-master arbiter for the ADS bus. Samples request lines from master 1 and master 2, grants the bus to one master at a time with round-robin fairness and a bounded hold time, and drives `master_select` into the control mux/decoder stage directly downstream. A fixed handover gap between owners lets the decoder's two-cycle pipeline drain before the mux switches masters.

---
 rtl/bus_pkg.sv | 40 ++++
 rtl/arb_hold_counter.sv | 30 +++
 rtl/bus_arbiter.sv | 117 +++++++++++
 tb/tb_bus_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master ADS bus arbiter.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package bus_pkg;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT_M1 = 2'b01,
    GRANT_M2 = 2'b10,
    HANDOVER = 2'b11
  } state_t;

  // Owner encoding matches master_select polarity (1 = master 1 routed).
  localparam logic OWNER_M1 = 1'b1;
  localparam logic OWNER_M2 = 1'b0;

  // Pipeline depth of the downstream control decoder.
  localparam int DECODER_LATENCY = 2;

  // Bits needed to count 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Arbitration decision shared by IDLE and the end of HANDOVER:
  // a lone requester wins, a tie goes to whoever did not own the bus last.
  function automatic state_t pick_owner(input logic r1, input logic r2,
                                        input logic last_owner);
    if (r1 && r2)
      return (last_owner == OWNER_M1) ? GRANT_M2 : GRANT_M1;
    else if (r1)
      return GRANT_M1;
    else if (r2)
      return GRANT_M2;
    else
      return IDLE;
  endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
// Count updates one cycle after enable; o_tc is combinational from the count.
// No backpressure: the counter simply stops at TERMINAL.
module arb_hold_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] r_cnt;

  // Count up while enabled, hold at the terminal value, clear has priority.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TC_VAL)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded hold and fixed handover gap.
// Grant follows a sampled request by one cycle; all outputs are registered.
// Owner is preempted after MAX_HOLD cycles only while the other master waits.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD        = 16,
  parameter int HANDOVER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  output logic grant1,
  output logic grant2,
  output logic master_select,
  output logic bus_busy
);

  localparam int HOLD_W = cnt_width(MAX_HOLD);
  localparam int HAND_W = cnt_width(HANDOVER_CYCLES);

  state_t r_state;
  state_t w_next;
  logic   r_last_owner, w_last_owner;
  logic   r_grant1, r_grant2, r_master_select, r_bus_busy;
  logic   w_grant1, w_grant2, w_master_select, w_bus_busy;
  logic   w_hold_tc, w_hand_tc;
  logic   w_hold_stay, w_hand_stay;

  // Counters only advance while the FSM stays put; any state change restarts them.
  assign w_hold_stay = ((r_state == GRANT_M1) || (r_state == GRANT_M2)) && (w_next == r_state);
  assign w_hand_stay = (r_state == HANDOVER) && (w_next == HANDOVER);

  arb_hold_counter #(
    .WIDTH    (HOLD_W),
    .TERMINAL (MAX_HOLD - 1)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_hold_stay),
    .i_en  (w_hold_stay),
    .o_tc  (w_hold_tc)
  );

  arb_hold_counter #(
    .WIDTH    (HAND_W),
    .TERMINAL (HANDOVER_CYCLES - 1)
  ) u_hand_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_hand_stay),
    .i_en  (w_hand_stay),
    .o_tc  (w_hand_tc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the values the output registers take on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = pick_owner(req1, req2, r_last_owner);
      GRANT_M1: if (!req1 || (req2 && w_hold_tc)) w_next = HANDOVER;
      GRANT_M2: if (!req2 || (req1 && w_hold_tc)) w_next = HANDOVER;
      HANDOVER: if (w_hand_tc) w_next = pick_owner(req1, req2, r_last_owner);
      default:  w_next = IDLE;
    endcase

    w_grant1   = (w_next == GRANT_M1);
    w_grant2   = (w_next == GRANT_M2);
    w_bus_busy = (w_next != IDLE);

    // Mux select only moves together with a new grant, never in the gap.
    w_master_select = r_master_select;
    if (w_next == GRANT_M1)
      w_master_select = OWNER_M1;
    else if (w_next == GRANT_M2)
      w_master_select = OWNER_M2;

    w_last_owner = r_last_owner;
    if ((r_state == GRANT_M1) && (w_next != GRANT_M1))
      w_last_owner = OWNER_M1;
    else if ((r_state == GRANT_M2) && (w_next != GRANT_M2))
      w_last_owner = OWNER_M2;
  end

  // Registered outputs and ownership history; reset favours master 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant1        <= 1'b0;
      r_grant2        <= 1'b0;
      r_master_select <= OWNER_M1;
      r_bus_busy      <= 1'b0;
      r_last_owner    <= OWNER_M2;
    end else begin
      r_grant1        <= w_grant1;
      r_grant2        <= w_grant2;
      r_master_select <= w_master_select;
      r_bus_busy      <= w_bus_busy;
      r_last_owner    <= w_last_owner;
    end
  end

  assign grant1        = r_grant1;
  assign grant2        = r_grant2;
  assign master_select = r_master_select;
  assign bus_busy      = r_bus_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed sequences,
// and randomized requests compared against a cycle-level reference model.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 16;
  localparam int HC       = 2;

  logic clk = 1'b0;
  logic rst, req1, req2;
  logic grant1, grant2, master_select, bus_busy;

  always #5 clk = ~clk;

  bus_arbiter #(
    .MAX_HOLD        (MAX_HOLD),
    .HANDOVER_CYCLES (HC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req1          (req1),
    .req2          (req2),
    .grant1        (grant1),
    .grant2        (grant2),
    .master_select (master_select),
    .bus_busy      (bus_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, for how long, and idle gap left.
  int   m_owner;  // 0 none, 1 master 1, 2 master 2
  int   m_held;   // cycles the current owner has had the grant
  int   m_gap;    // handover cycles still to run (including the current one)
  int   m_last;   // last owner, 1 or 2
  logic m_sel;

  logic prev_g1, prev_g2, prev_sel;

  typedef struct {
    bit         rs;
    bit         r1;
    bit         r2;
    logic [3:0] exp;  // {grant1, grant2, master_select, bus_busy}
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic int choose(input bit r1, input bit r2, input int last);
    if (r1 && r2) return (last == 1) ? 2 : 1;
    if (r1) return 1;
    if (r2) return 2;
    return 0;
  endfunction

  task automatic model_step(input bit r1, input bit r2, input bit rs);
    bit own, other;
    if (rs) begin
      m_owner = 0; m_held = 0; m_gap = 0; m_last = 2; m_sel = 1'b1;
      return;
    end
    if (m_owner != 0) begin
      own   = (m_owner == 1) ? r1 : r2;
      other = (m_owner == 1) ? r2 : r1;
      if (!own || (other && m_held >= MAX_HOLD)) begin
        m_last  = m_owner;
        m_owner = 0;
        m_gap   = HC;
      end else begin
        m_held++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap   = 0;
      m_owner = choose(r1, r2, m_last);
      if (m_owner != 0) begin
        m_held = 1;
        m_sel  = (m_owner == 1);
      end
    end
  endtask

  // One clock: drive, step model at the edge, then check model and invariants.
  task automatic cycle(input bit r1, input bit r2, input bit rs, input string tag);
    logic [3:0] exp;
    bit ok;
    req1 = r1; req2 = r2; rst = rs;
    @(posedge clk);
    model_step(r1, r2, rs);
    #1;
    exp = {m_owner == 1, m_owner == 2, m_sel, (m_owner != 0) || (m_gap > 0)};
    check({tag, "/model"}, {grant1, grant2, master_select, bus_busy}, exp);
    check({tag, "/exclusive"}, {2'b00, grant1, grant2} & 4'b0011 & {3'b000, grant1 & grant2}, 4'b0000);
    ok = rs || (master_select === prev_sel) || (grant1 && !prev_g1) || (grant2 && !prev_g2);
    check({tag, "/sel_moves_with_grant"}, {3'b000, ok}, 4'b0001);
    prev_g1 = grant1; prev_g2 = grant2; prev_sel = master_select;
  endtask

  function automatic int contention_owner(input int p);
    int q;
    q = p % (2 * (MAX_HOLD + HC));
    if (q < MAX_HOLD) return 1;
    if (q < MAX_HOLD + HC) return 0;
    if (q < 2 * MAX_HOLD + HC) return 2;
    return 0;
  endfunction

  initial begin
    int cnt, seen;
    bit r1, r2, rs;

    prev_g1 = 1'b0; prev_g2 = 1'b0; prev_sel = 1'b1;
    m_owner = 0; m_held = 0; m_gap = 0; m_last = 2; m_sel = 1'b1;

    tbl[0]  = '{1, 0, 0, 4'b0010};  // reset values
    tbl[1]  = '{0, 0, 0, 4'b0010};
    tbl[2]  = '{0, 1, 0, 4'b1011};  // lone req1: grant next cycle
    tbl[3]  = '{0, 1, 1, 4'b1011};
    tbl[4]  = '{0, 0, 1, 4'b0011};  // release: handover keeps select
    tbl[5]  = '{0, 0, 1, 4'b0011};
    tbl[6]  = '{0, 0, 1, 4'b0101};  // gap done: master 2
    tbl[7]  = '{0, 0, 1, 4'b0101};
    tbl[8]  = '{0, 0, 0, 4'b0001};
    tbl[9]  = '{0, 1, 0, 4'b0001};  // request mid-handover not acted on
    tbl[10] = '{0, 1, 1, 4'b1011};  // tie after M2: master 1
    tbl[11] = '{1, 1, 1, 4'b0010};  // reset mid-grant
    tbl[12] = '{0, 1, 1, 4'b1011};  // tie after reset: master 1
    tbl[13] = '{0, 0, 0, 4'b0011};
    tbl[14] = '{0, 0, 0, 4'b0011};
    tbl[15] = '{0, 0, 0, 4'b0010};  // no request after gap: idle
    tbl[16] = '{0, 0, 1, 4'b0101};
    tbl[17] = '{0, 0, 0, 4'b0001};
    tbl[18] = '{0, 0, 0, 4'b0001};
    tbl[19] = '{0, 0, 0, 4'b0000};  // idle, select stays at master 2
    tbl[20] = '{0, 1, 1, 4'b1011};  // tie after M2: master 1

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].r1, tbl[i].r2, tbl[i].rs, $sformatf("vec%0d", i));
      check($sformatf("vec%0d/table", i), {grant1, grant2, master_select, bus_busy}, tbl[i].exp);
    end

    // Continuous contention: fixed-length alternating grants with gaps.
    cycle(0, 0, 1, "cont_rst");
    cycle(0, 0, 0, "cont_idle");
    for (int p = 0; p < 90; p++) begin
      cycle(1, 1, 0, "cont");
      seen = grant1 ? 1 : (grant2 ? 2 : 0);
      check($sformatf("cont_owner_p%0d", p), 4'(seen), 4'(contention_owner(p)));
    end

    // Lone master 2 for 40 cycles: no preemption without contention.
    cycle(0, 0, 1, "solo_rst");
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(0, 1, 0, "solo");
      if (grant2) cnt++;
    end
    check("solo_grant2_cycles", 4'(cnt == 40), 4'd1);
    // Saturated hold counter: contention now preempts immediately.
    cycle(1, 1, 0, "preempt");
    check("preempt_after_sat", {grant1, grant2, master_select, bus_busy}, 4'b0001);
    cycle(1, 1, 0, "preempt_gap");
    cycle(1, 1, 0, "preempt_next");
    check("preempt_next_owner", {grant1, grant2, master_select, bus_busy}, 4'b1011);

    // Reset while master 2 owns the bus.
    cycle(0, 0, 1, "rstm2_rst");
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, "rstm2_grant");
    check("rstm2_granted", {grant1, grant2, master_select, bus_busy}, 4'b0101);
    cycle(0, 1, 1, "rstm2_hit");
    check("rstm2_after_reset", {grant1, grant2, master_select, bus_busy}, 4'b0010);
    cycle(1, 1, 0, "rstm2_tie");
    check("rstm2_tie_m1_wins", {grant1, grant2, master_select, bus_busy}, 4'b1011);

    // Randomized requests with occasional resets against the model.
    r1 = 0; r2 = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7, 0) == 0) r1 = ~r1;
      if ($urandom_range(7, 0) == 0) r2 = ~r2;
      rs = ($urandom_range(299, 0) == 0);
      cycle(r1, r2, rs, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
